// File: rtl/heart_rom_arbiter.sv
// heart_rom_arbiter: round-robin sharing of one registered-output heart sprite ROM among N_REQ requesters
module heart_rom_arbiter #(
  parameter int N_REQ = 4,
  parameter int SPRITE_W = 64,
  parameter int SPRITE_H = 20
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_REQ-1:0]                    req,
  input  logic [$clog2(SPRITE_W)*N_REQ-1:0]   req_x,
  input  logic [6*N_REQ-1:0]                  req_y,
  output logic [N_REQ-1:0]                    grant,
  output logic [$clog2(SPRITE_W)-1:0]         rom_x,
  output logic [5:0]                          rom_y,
  input  logic [15:0]                         rom_rgb,
  output logic                                rsp_valid,
  output logic [2:0]                          rsp_id,
  output logic [15:0]                         rsp_rgb
);
  localparam int XW = $clog2(SPRITE_W);
  localparam logic [5:0] H = 6'(SPRITE_H);
  logic [2:0] last, s1_id, win;
  logic s1_oob, oob_q, found;
  int j;
  // search begins just after the last winner so every requester is reached within N_REQ grants
  always_comb begin
    found = 1'b0;
    win = last;
    j = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(last) + k) % N_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        win = 3'(j);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      grant <= '0;
      rom_x <= '0;
      rom_y <= '0;
      s1_id <= '0;
      s1_oob <= 1'b0;
      last <= 3'(N_REQ - 1);
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      oob_q <= 1'b0;
    end else begin
      grant <= found ? N_REQ'(1) << win : '0;
      if (found) begin
        rom_x <= req_x[XW*win +: XW];
        rom_y <= req_y[6*win +: 6];
        s1_id <= win;
        s1_oob <= req_y[6*win +: 6] >= H;
        last <= win;
      end
      rsp_valid <= |grant;
      rsp_id <= s1_id;
      oob_q <= s1_oob;
    end
  end
  // rom_rgb is already registered inside the ROM, so masking stays combinational
  assign rsp_rgb = oob_q ? 16'h0000 : rom_rgb;
endmodule

// File: tb/tb_heart_rom_arbiter.sv
// tb_heart_rom_arbiter: directed checks of arbitration, rotation, range masking and reset
module tb_heart_rom_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req = '0, grant;
  logic [23:0] req_x = '0, req_y = '0;
  logic [5:0] rom_x, rom_y;
  logic [15:0] rom_rgb = '0, rsp_rgb;
  logic rsp_valid;
  logic [2:0] rsp_id;
  int checks = 0, errors = 0;

  heart_rom_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y),
    .grant(grant), .rom_x(rom_x), .rom_y(rom_y), .rom_rgb(rom_rgb),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rgb(rsp_rgb)
  );

  always #5 clk = ~clk;

  // ROM stand-in: transparent at column 0, red inside the sprite, white past the defined rows
  always @(posedge clk)
    rom_rgb <= (rom_x == 0) ? 16'h0000 : (rom_y >= 20) ? 16'hFFFF : 16'hF800;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    req = 4'b1111;
    step();
    step();
    chk("rst_grant", grant, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_x", rom_x, 0);
    chk("rst_y", rom_y, 0);
    rst = 1'b0;
    step();
    chk("first_grant", grant, 4'b0001);
    req = '0;
    step();
    chk("first_rsp_valid", rsp_valid, 1);
    chk("first_rsp_id", rsp_id, 0);
    step();
    chk("idle_valid", rsp_valid, 0);

    req_x[5:0] = 6'd5;
    req_y[5:0] = 6'd3;
    req = 4'b0001;
    step();
    chk("single_grant", grant, 4'b0001);
    chk("single_x", rom_x, 5);
    chk("single_y", rom_y, 3);
    req = '0;
    req_x[5:0] = 6'd9;
    step();
    chk("single_valid", rsp_valid, 1);
    chk("single_id", rsp_id, 0);
    chk("single_rgb", rsp_rgb, 16'hF800);
    chk("single_grant_idle", grant, 0);
    req_x[5:0] = 6'd0;
    req = 4'b0001;
    step();
    req = '0;
    step();
    chk("x0_valid", rsp_valid, 1);
    chk("x0_rgb", rsp_rgb, 16'h0000);

    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_x[6*i +: 6] = 6'(i + 1);
      req_y[6*i +: 6] = 6'(i + 10);
    end
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rot_grant", grant, 4'b0001 << (k % 4));
      chk("rot_x", rom_x, (k % 4) + 1);
      chk("rot_y", rom_y, (k % 4) + 10);
      if (k > 0) begin
        chk("rot_valid", rsp_valid, 1);
        chk("rot_id", rsp_id, (k - 1) % 4);
      end
    end
    req = '0;
    step();
    chk("rot_last_valid", rsp_valid, 1);
    chk("rot_last_id", rsp_id, 3);

    req = 4'b0100;
    step();
    chk("wrap_g2", grant, 4'b0100);
    req = 4'b0101;
    step();
    chk("wrap_g0", grant, 4'b0001);
    step();
    chk("wrap_g2_again", grant, 4'b0100);
    req = '0;
    step();
    step();

    req_x[11:6] = 6'd10;
    req_y[11:6] = 6'd25;
    req = 4'b0010;
    step();
    chk("oob_grant", grant, 4'b0010);
    chk("oob_y", rom_y, 25);
    req = '0;
    step();
    chk("oob_valid", rsp_valid, 1);
    chk("oob_id", rsp_id, 1);
    chk("oob_rom_raw", rom_rgb, 16'hFFFF);
    chk("oob_rgb", rsp_rgb, 16'h0000);

    req = 4'b1000;
    step();
    chk("mid_grant", grant, 4'b1000);
    rst = 1'b1;
    req = '0;
    step();
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_grant", grant, 0);
    step();
    chk("mid_rst_valid2", rsp_valid, 0);
    rst = 1'b0;
    req = 4'b1000;
    step();
    chk("post_grant", grant, 4'b1000);
    chk("post_no_stale", rsp_valid, 0);
    req = '0;
    step();
    chk("post_valid", rsp_valid, 1);
    chk("post_id", rsp_id, 3);
    step();
    chk("post_idle", rsp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
